// File: rtl/acc_requant_packer.sv
// Requantizes 64-bit accumulator beats (scale, rounding shift, ReLU, saturation) and packs
// them SWAR-style into 16-bit activation words behind a small output FIFO.
module acc_requant_packer #(
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [ACC_WIDTH-1:0]  acc_data,
  input  logic                  acc_last,
  input  logic [1:0]            precision_mode,
  input  logic [15:0]           scale,
  input  logic [5:0]            shift,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           sat_count
);

  localparam logic [1:0] MODE_INT4  = 2'd0;
  localparam logic [1:0] MODE_INT8  = 2'd1;
  localparam logic [1:0] MODE_INT16 = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam int unsigned PW = ACC_WIDTH + 16;
  // One guard bit so the rounding add can never wrap.
  localparam int unsigned XW = PW + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic                  ready_en;
  logic                  s1_v, s1_last, s1_relu;
  logic signed [PW-1:0]  s1_prod;
  logic [1:0]            s1_mode;
  logic [5:0]            s1_shift;
  logic                  s2_v, s2_last;
  logic [1:0]            s2_mode;
  logic [DATA_WIDTH-1:0] s2_val;
  logic [1:0]            k;
  logic [DATA_WIDTH-1:0] part;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;

  logic                  accept, push, pop, empty, sat_hit;
  logic signed [PW-1:0]  prod_d;
  logic signed [XW-1:0]  prod_x, half, shifted, r, hi, lo;
  logic [DATA_WIDTH-1:0] s2_val_d, lane_bits, word_next;
  logic [3:0]            lane_sh;
  logic                  last_lane;
  logic [AW+1:0]         used_credits;

  assign empty        = (count == '0);
  assign used_credits = {1'b0, count} + (AW + 2)'(s1_v) + (AW + 2)'(s2_v);
  assign acc_ready    = ready_en & (used_credits < (AW + 2)'(FIFO_DEPTH));
  assign accept       = acc_valid & acc_ready;
  assign out_valid    = !empty;
  assign pop          = out_valid & out_ready;
  assign out_data     = empty ? '0 : mem[rd_ptr][DATA_WIDTH-1:0];
  assign out_last     = empty ? 1'b0 : mem[rd_ptr][DATA_WIDTH];
  assign busy         = s1_v | s2_v | (k != 2'd0) | !empty;
  assign prod_d       = PW'($signed(acc_data)) * PW'($signed(scale));

  // S2 arithmetic: round half up, optional ReLU, clamp to the lane range.
  always_comb begin
    prod_x  = {s1_prod[PW-1], s1_prod};
    half    = '0;
    shifted = prod_x;
    if (s1_shift != 6'd0) begin
      half    = XW'(1) << (s1_shift - 6'd1);
      shifted = (prod_x + half) >>> s1_shift;
    end
    r = (s1_relu && shifted[XW-1]) ? '0 : shifted;
    case (s1_mode)
      MODE_INT4: hi = XW'(7);
      MODE_INT8: hi = XW'(127);
      default:   hi = XW'(32767);
    endcase
    lo       = ~hi;
    sat_hit  = 1'b0;
    s2_val_d = r[DATA_WIDTH-1:0];
    if (r > hi) begin
      s2_val_d = hi[DATA_WIDTH-1:0];
      sat_hit  = 1'b1;
    end else if (r < lo) begin
      s2_val_d = lo[DATA_WIDTH-1:0];
      sat_hit  = 1'b1;
    end
    if (s1_mode == MODE_RSVD) begin
      s2_val_d = '0;
      sat_hit  = 1'b0;
    end
  end

  always_comb begin
    case (s2_mode)
      MODE_INT4: begin
        lane_bits = {{(DATA_WIDTH - 4){1'b0}}, s2_val[3:0]};
        lane_sh   = {k, 2'b00};
        last_lane = (k == 2'd3);
      end
      MODE_INT8: begin
        lane_bits = {{(DATA_WIDTH - 8){1'b0}}, s2_val[7:0]};
        lane_sh   = {k[0], 3'b000};
        last_lane = k[0];
      end
      default: begin
        lane_bits = s2_val;
        lane_sh   = 4'd0;
        last_lane = 1'b1;
      end
    endcase
    word_next = part | (lane_bits << lane_sh);
    push      = s2_v & (last_lane | s2_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_relu   <= 1'b0;
      s1_prod   <= '0;
      s1_mode   <= MODE_INT4;
      s1_shift  <= '0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      s2_mode   <= MODE_INT4;
      s2_val    <= '0;
      k         <= '0;
      part      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sat_count <= '0;
    end else begin
      ready_en <= 1'b1;
      s1_v     <= accept;
      if (accept) begin
        s1_prod  <= prod_d;
        s1_last  <= acc_last;
        s1_mode  <= precision_mode;
        s1_shift <= shift;
        s1_relu  <= relu_en;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_val  <= s2_val_d;
        s2_last <= s1_last;
        s2_mode <= s1_mode;
        if (sat_hit && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
      end
      if (s2_v) begin
        if (push) begin
          k    <= '0;
          part <= '0;
        end else begin
          k    <= k + 2'd1;
          part <= word_next;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s2_last, word_next};
  end

endmodule

// File: tb/tb_acc_requant_packer.sv
// Bench for acc_requant_packer: directed scenarios plus randomized tiles checked against
// an arithmetic reference model of requantization and lane packing.
module tb_acc_requant_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_valid = 1'b0, acc_ready, acc_last = 1'b0;
  logic [63:0] acc_data = '0;
  logic [1:0]  precision_mode = 2'd2;
  logic [15:0] scale = 16'd1;
  logic [5:0]  shift = 6'd0;
  logic        relu_en = 1'b0;
  logic        out_valid, out_ready = 1'b1, out_last, busy;
  logic [15:0] out_data, sat_count;

  int tests = 0, fails = 0;
  logic [16:0] got[$], exp_q[$];
  int exp_sat = 0, mk = 0;
  logic [15:0] mword = '0;
  bit rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  acc_requant_packer dut (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .acc_last(acc_last), .precision_mode(precision_mode),
    .scale(scale), .shift(shift), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .sat_count(sat_count)
  );

  // Reference: exact product, round half up, ReLU, clamp; RSVD yields 0 without saturation.
  function automatic logic [15:0] ref_val(input logic [63:0] d, input logic [1:0] m,
                                          input logic [15:0] sc, input logic [5:0] sh,
                                          input bit relu, output bit sat);
    logic signed [127:0] a, s, p;
    longint hi;
    a = $signed(d);
    s = $signed(sc);
    p = a * s;
    if (sh != 0) p = (p + (128'sd1 <<< (sh - 1))) >>> sh;
    if (relu && p < 0) p = 0;
    sat = 1'b0;
    if (m == 2'd3) return 16'h0;
    hi = (m == 2'd0) ? 7 : (m == 2'd1) ? 127 : 32767;
    if (p > hi) begin p = hi; sat = 1'b1; end
    else if (p < -hi - 1) begin p = -hi - 1; sat = 1'b1; end
    return p[15:0];
  endfunction

  // Monitor: model every accepted beat and record every popped word.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      mk = 0; mword = '0; exp_sat = 0;
    end else begin
      if (out_valid && out_ready) got.push_back({out_last, out_data});
      if (acc_valid && acc_ready) begin
        bit s;
        int w, tmp;
        logic [15:0] v;
        v = ref_val(acc_data, precision_mode, scale, shift, relu_en, s);
        if (s && exp_sat < 65535) exp_sat++;
        w = (precision_mode == 2'd0) ? 4 : (precision_mode == 2'd1) ? 8 : 16;
        tmp = (int'(v) & ((1 << w) - 1)) << (mk * w);
        mword = mword | tmp[15:0];
        if (mk == 16 / w - 1 || acc_last) begin
          exp_q.push_back({acc_last, mword});
          mk = 0; mword = '0;
        end else mk++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [63:0] d, input bit l);
    int n = 0;
    acc_data = d; acc_last = l; acc_valid = 1'b1;
    while (!acc_ready && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (!acc_ready) begin fails++; $display("FAIL send_timeout got ready=0 exp ready=1"); end
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    rnd_rdy = 1'b0; out_ready = 1'b1;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    ok = !busy;
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [15:0] sc, input logic [5:0] sh,
                         input bit re);
    precision_mode = m; scale = sc; shift = sh; relu_en = re;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (acc_ready !== 1'b0) begin fails++; $display("FAIL rst_acc_ready got %b exp 0", acc_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last got %b exp 0", out_last); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    tests++; if (sat_count !== 16'h0) begin fails++; $display("FAIL rst_sat got %h exp 0", sat_count); end
    rst_n = 1'b1;
    #1;
    tests++; if (acc_ready !== 1'b0) begin fails++; $display("FAIL post_rst_ready got %b exp 0", acc_ready); end
    @(negedge clk);
    tests++; if (acc_ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b exp 1", acc_ready); end
  endtask

  task automatic test_int16_latency;
    bit ok;
    set_cfg(2'd2, 16'd1, 6'd0, 1'b0);
    got.delete();
    acc_data = 64'h1234; acc_last = 1'b1; acc_valid = 1'b1;
    tests++; if (acc_ready !== 1'b1) begin fails++; $display("FAIL lat_ready got %b exp 1", acc_ready); end
    @(negedge clk);
    acc_valid = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tests++;
      if (out_valid !== (n == 3)) begin
        fails++; $display("FAIL lat_valid_c%0d got %b exp %b", n, out_valid, n == 3);
      end
      if (n < 3) @(negedge clk);
    end
    tests++; if (out_data !== 16'h1234 || out_last !== 1'b1) begin
      fails++; $display("FAIL lat_word got %h/%b exp 1234/1", out_data, out_last);
    end
    wait_idle(ok);
    tests++; if (!ok || got.size() != 1) begin
      fails++; $display("FAIL lat_count got %0d exp 1", got.size());
    end
  endtask

  task automatic test_int8;
    bit ok;
    set_cfg(2'd1, 16'd3, 6'd2, 1'b0);
    got.delete();
    send(64'd5, 1'b0);
    send(-64'sd5, 1'b1);
    wait_idle(ok);
    tests++; if (!ok || got.size() != 1 || got[0] !== 17'h1_FC04) begin
      fails++; $display("FAIL int8_word got %0d/%h exp 1/1fc04", got.size(), got[0]);
    end
    tests++; if (sat_count !== 16'd0) begin fails++; $display("FAIL int8_sat got %0d exp 0", sat_count); end
  endtask

  task automatic test_int4;
    bit ok;
    for (int re = 0; re < 2; re++) begin
      set_cfg(2'd0, 16'd1, 6'd0, re[0]);
      got.delete();
      send(64'd100, 1'b0);
      send(-64'sd100, 1'b0);
      send(64'd1, 1'b0);
      send(64'd0, 1'b1);
      wait_idle(ok);
      tests++; if (!ok || got.size() != 1 || got[0] !== (re ? 17'h1_0107 : 17'h1_0187)) begin
        fails++; $display("FAIL int4_word_relu%0d got %0d/%h", re, got.size(), got[0]);
      end
      tests++; if (sat_count !== 16'(2 + re)) begin
        fails++; $display("FAIL int4_sat_relu%0d got %0d exp %0d", re, sat_count, 2 + re);
      end
    end
  endtask

  task automatic test_partial;
    bit ok;
    set_cfg(2'd0, 16'd1, 6'd0, 1'b0);
    got.delete();
    send(64'd3, 1'b0);
    send(64'd2, 1'b1);
    send(64'd5, 1'b1);
    wait_idle(ok);
    tests++; if (!ok || got.size() != 2 || got[0] !== 17'h1_0023 || got[1] !== 17'h1_0005) begin
      fails++; $display("FAIL partial got %0d/%h/%h exp 2/10023/10005", got.size(), got[0], got[1]);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int accepted = 0, nxt = 1, n = 0;
    set_cfg(2'd2, 16'd1, 6'd0, 1'b0);
    got.delete();
    out_ready = 1'b0;
    acc_last = 1'b0; acc_data = 64'd1; acc_valid = 1'b1;
    repeat (10) begin
      if (acc_ready) begin accepted++; nxt++; end
      @(negedge clk);
      acc_data = 64'(nxt);
      acc_valid = (nxt <= 6);
    end
    tests++; if (accepted != 4) begin fails++; $display("FAIL bp_accepted got %0d exp 4", accepted); end
    tests++; if (acc_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got %b exp 0", acc_ready); end
    tests++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin
      fails++; $display("FAIL bp_head got %b/%h exp 1/0001", out_valid, out_data);
    end
    out_ready = 1'b1;
    while (nxt <= 6 && n < 200) begin
      if (acc_ready) nxt++;
      @(negedge clk);
      acc_data = 64'(nxt);
      acc_valid = (nxt <= 6);
      n++;
    end
    acc_valid = 1'b0;
    wait_idle(ok);
    tests++; if (!ok || got.size() != 6) begin fails++; $display("FAIL bp_count got %0d exp 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (got[i] !== 17'(i + 1)) begin fails++; $display("FAIL bp_word%0d got %h exp %h", i, got[i], i + 1); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    set_cfg(2'd1, 16'd1, 6'd0, 1'b0);
    send(64'd9, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || sat_count !== 16'd0) begin
      fails++; $display("FAIL midrst got v%b b%b s%0d exp v0 b0 s0", out_valid, busy, sat_count);
    end
    got.delete(); exp_q.delete();
    @(negedge clk);
    send(64'h11, 1'b0);
    send(64'h22, 1'b1);
    wait_idle(ok);
    tests++; if (!ok || got.size() != 1 || got[0] !== 17'h1_2211) begin
      fails++; $display("FAIL midrst_word got %0d/%h exp 1/12211", got.size(), got[0]);
    end
  endtask

  task automatic test_random;
    bit ok;
    got.delete(); exp_q.delete();
    for (int t = 0; t < 30; t++) begin
      int len;
      wait_idle(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rnd_idle%0d got busy exp idle", t); end
      set_cfg(2'($urandom_range(0, 3)), 16'($urandom),
              6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12)),
              1'($urandom_range(0, 1)));
      rnd_rdy = 1'b1;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        logic [63:0] d;
        if ($urandom_range(0, 3) == 0) d = {$urandom, $urandom};
        else d = 64'($signed($urandom_range(0, 4000)) - 2000);
        send(d, i == len - 1);
      end
    end
    wait_idle(ok);
    tests++; if (!ok || got.size() != exp_q.size()) begin
      fails++; $display("FAIL rnd_count got %0d exp %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rnd_word%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    tests++; if (sat_count !== 16'(exp_sat)) begin
      fails++; $display("FAIL rnd_sat got %0d exp %0d", sat_count, exp_sat);
    end
  endtask

  initial begin
    test_reset();
    test_int16_latency();
    test_int8();
    test_int4();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acc_requant_packer.md
Name: acc_requant_packer

Overview:
- Sits directly downstream of the systolic array bottom row.
- Consumes the 64-bit accumulators drained from one column (one value per accepted beat).
- Requantizes each value: scale multiply, rounding arithmetic right shift, optional ReLU, saturation to the active precision.
- Packs results SWAR-style into 16-bit words in the same lane layout the PEs consume, so outputs feed straight back as next-layer activations.

Parameters:
- ACC_WIDTH, 64, accumulator input width (`ACC_WIDTH).
- DATA_WIDTH, 16, packed output word width (`DATA_WIDTH).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- acc_valid  in  1  accumulator beat valid.
- acc_ready  out  1  block can accept a beat.
- acc_data  in  ACC_WIDTH  signed accumulator.
- acc_last  in  1  final accumulator of the tile; forces flush of a partial word.
- precision_mode  in  precision_mode_t  MODE_INT4/INT8/INT16/RSVD.
- scale  in  16  signed requant multiplier.
- shift  in  6  right-shift amount, 0..63.
- relu_en  in  1  clamp negatives to 0 before saturation.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  DATA_WIDTH  packed word.
- out_last  out  1  word contains the tile's last value.
- busy  out  1  any stage, partial pack, or FIFO occupied.
- sat_count  out  16  saturating count of clamped values since reset.

Behaviour:
- Synchronous active-low reset clears all stage valids, partial lane state, FIFO pointers, and sat_count.
- During reset and on the cycle after it: acc_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, sat_count=0.
- Config inputs (precision_mode, scale, shift, relu_en) are sampled per beat at S1 and carried along with that beat.
- Changing config mid-tile is allowed only with busy=0; otherwise results are undefined.
- Acceptance: a beat is accepted when acc_valid && acc_ready.
- Flow control: acc_ready = (fifo_count + s1_v + s2_v) < FIFO_DEPTH. This credit rule guarantees no FIFO overflow.
- S1 (register): prod = acc_data * sign-extended scale, 80-bit signed full product; last and config travel with it.
- S2 (register):
  - r = (shift==0) ? prod : (prod + (1<<(shift-1))) >>> shift. This rounds half up (toward +inf); computed at 80 bits with no overflow.
  - If relu_en and r<0, then r=0.
  - Saturate to [-8,7] for INT4, [-128,127] for INT8, [-32768,32767] for INT16.
  - Each clamp increments sat_count, which holds at 0xFFFF.
  - RSVD: value forced to 0; no sat count.
- Pack (combinational from S2, writes FIFO in S2's cycle):
  - Lane index k starts at 0. Lanes per word: INT4=4, INT8=2, INT16=1.
  - Value goes into bits [k*W+W-1 : k*W], where W = 4, 8, or 16 (lane 0 = LSBs).
  - The word is pushed when k reaches lanes-1 or S2 carries last.
  - Unfilled lanes are zero-padded. out_last = last. k resets to 0 after a push.
  - RSVD: treat as INT16 lanes.
- Latency: a beat accepted at edge T is in S1 after T, in S2 after T+1, and pushed to the FIFO at T+2. out_valid is high at the earliest in the cycle after edge T+2 (3 cycles, INT16).
- Throughput: 1 beat/cycle when out_ready=1.
- FIFO: out_valid = !empty; the head is presented.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop is permitted at full and at empty. At empty, the pushed word appears in the next cycle; there is no fall-through.
  - out_data and out_last hold while out_valid && !out_ready.
- Pipeline stages never stall; backpressure is applied solely via acc_ready.
- busy = s1_v | s2_v | (k!=0) | !empty.
- A partial word with no last stays held until more beats arrive.

Test Plan:
- INT16, scale=1, shift=0: acc=0x1234, last=1 → out_data=0x1234, out_last=1, out_valid first high 3 cycles after accept.
- INT8, scale=3, shift=2: acc=5 then acc=-5 (last) → lanes 4 and -4 → out_data=0xFC04 (one word); sat_count=0.
- INT4, scale=1, shift=0: acc=100, -100, 1, 0 → 7, -8, 1, 0 → out_data=0x0187; sat_count=2. Repeat with relu_en=1 → 0x0107, sat_count +1.
- INT4 partial flush: acc=3, acc=2 (last) → out_data=0x0023, out_last=1; the next tile's first value lands in lane 0.
- Backpressure: INT16, out_ready=0, acc_valid held for 6 beats 1..6 → exactly 4 accepted and acc_ready=0. Then out_ready=1 → words 1,2,3,4 then 5,6 in order; no loss or duplication.
- Reset mid-tile: after 1 INT8 beat, pull rst_n low for 1 cycle → out_valid=0, busy=0, sat_count=0. The next 2 beats form a fresh word with no stale lane.
